// File: rtl/fetch_stream_pkg.sv
// Shared defaults, state encoding and address helpers for the fetch front end.
package fetch_stream_pkg;

   localparam int WORD_SIZE_DEF   = 32;
   localparam int BLOCK_WORDS_DEF = 32;
   localparam int ADDR_W_DEF      = 32;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_DROP   = 3'd3,
      S_STREAM = 3'd4
   } state_t;

   // Number of low byte-address bits covered by one block.
   function automatic int blk_lsb_bits(input int block_words);
      return $clog2(block_words) + 2;
   endfunction

endpackage

// File: rtl/fetch_stream_block_word_sel.sv
// Selects word[ptr] from a cache line; word 0 occupies the most significant bits.
module fetch_stream_block_word_sel
   import fetch_stream_pkg::*;
#(
   parameter int WORD_SIZE   = WORD_SIZE_DEF,
   parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
   parameter int OFF_W       = $clog2(BLOCK_WORDS),
   parameter int BLOCK_SIZE  = WORD_SIZE * BLOCK_WORDS
)(
   input  logic [BLOCK_SIZE-1:0] i_line,
   input  logic [OFF_W-1:0]      i_ptr,
   output logic [WORD_SIZE-1:0]  o_word
);

   logic [WORD_SIZE-1:0] w_words [BLOCK_WORDS];

   for (genvar k = 0; k < BLOCK_WORDS; k++) begin : g_unpack
      assign w_words[k] = i_line[BLOCK_SIZE-1-k*WORD_SIZE -: WORD_SIZE];
   end

   assign o_word = w_words[i_ptr];

endmodule

// File: rtl/fetch_stream.sv
// Instruction-fetch front end: requests one block at a time from the
// instruction cache and streams its words to decode, MSB word first.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | after reset, waiting for the first redirect
// S_REQ    | presenting a block request for the block holding pc
// S_WAIT   | request accepted, waiting for the block data
// S_DROP   | redirected while a request is outstanding; discard its data
// S_STREAM | issuing words of the held line to decode
module fetch_stream
   import fetch_stream_pkg::*;
#(
   parameter int WORD_SIZE   = WORD_SIZE_DEF,
   parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int BLOCK_SIZE  = WORD_SIZE * BLOCK_WORDS
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect_valid,
   input  logic [ADDR_W-1:0]     redirect_pc,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_W-1:0]     mem_req_addr,
   input  logic                  mem_resp_valid,
   input  logic [BLOCK_SIZE-1:0] mem_resp_block,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [WORD_SIZE-1:0]  inst,
   output logic [ADDR_W-1:0]     inst_pc,
   output logic [31:0]           inst_count
);

   localparam int OFF_W = $clog2(BLOCK_WORDS);
   localparam int LSB_W = blk_lsb_bits(BLOCK_WORDS);
   localparam logic [OFF_W-1:0]  LAST_PTR  = OFF_W'(BLOCK_WORDS - 1);
   localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << LSB_W) - ADDR_W'(1));

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_W-1:0]     r_pc;
   logic [OFF_W-1:0]      r_ptr;
   logic [BLOCK_SIZE-1:0] r_line;
   logic [31:0]           r_count;
   logic [WORD_SIZE-1:0]  w_word;
   logic                  w_xfer;
   logic                  w_fill;
   logic [ADDR_W-1:0]     w_redir_pc;

   // Redirect always wins over a same-cycle handshake or response.
   assign w_xfer     = (r_state == S_STREAM) && inst_ready && !redirect_valid;
   assign w_fill     = (r_state == S_WAIT) && mem_resp_valid && !redirect_valid;
   assign w_redir_pc = redirect_pc & ~ADDR_W'(3);

   fetch_stream_block_word_sel #(
      .WORD_SIZE   (WORD_SIZE),
      .BLOCK_WORDS (BLOCK_WORDS),
      .OFF_W       (OFF_W),
      .BLOCK_SIZE  (BLOCK_SIZE)
   ) u_sel (
      .i_line (r_line),
      .i_ptr  (r_ptr),
      .o_word (w_word)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (redirect_valid) w_state_nxt = S_REQ;
         S_REQ:    if (!redirect_valid && mem_req_ready) w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (redirect_valid)      w_state_nxt = mem_resp_valid ? S_REQ : S_DROP;
            else if (mem_resp_valid) w_state_nxt = S_STREAM;
         end
         S_DROP:   if (mem_resp_valid) w_state_nxt = S_REQ;
         S_STREAM: begin
            if (redirect_valid)                   w_state_nxt = S_REQ;
            else if (inst_ready && r_ptr == LAST_PTR) w_state_nxt = S_REQ;
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // PC, word pointer, line buffer and accepted-instruction counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc    <= '0;
         r_ptr   <= '0;
         r_line  <= '0;
         r_count <= '0;
      end else begin
         if (redirect_valid) begin
            r_pc <= w_redir_pc;
         end else if (w_xfer) begin
            r_pc    <= r_pc + ADDR_W'(4);
            r_ptr   <= r_ptr + OFF_W'(1);
            r_count <= r_count + 32'd1;
         end
         if (w_fill) begin
            r_line <= mem_resp_block;
            r_ptr  <= r_pc[LSB_W-1:2];
         end
      end
   end

   // Outputs; everything reads zero outside the state that drives it.
   always_comb begin
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      inst_valid    = 1'b0;
      inst          = '0;
      inst_pc       = '0;
      if (r_state == S_REQ) begin
         mem_req_valid = !redirect_valid;
         mem_req_addr  = r_pc & BASE_MASK;
      end
      if (r_state == S_STREAM) begin
         inst_valid = 1'b1;
         inst       = w_word;
         inst_pc    = r_pc;
      end
   end

   assign inst_count = r_count;

endmodule

// File: doc/fetch_stream.md
Name: fetch_stream

Overview:
- Parametrised instruction-fetch front end.
- Requests one cache block from the instruction cache and unpacks it into a stream of `WORD_SIZE` instructions, starting at the PC's word offset and working from MSB to LSB.
- Issues instructions over a valid/ready handshake, requests the next sequential block automatically, and flushes on redirect.
- Sits between instcache and decode.

Parameters:
- WORD_SIZE, 32: instruction width in bits.
- BLOCK_WORDS, 32: words per cache block (power of 2, ≥2). BLOCK_SIZE = WORD_SIZE*BLOCK_WORDS.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- redirect_valid  in  1  start or restart fetch.
- redirect_pc  in  ADDR_W  new byte PC; bits [1:0] ignored (treated as 0).
- mem_req_valid  out  1  block request.
- mem_req_ready  in  1  instcache accepts request.
- mem_req_addr  out  ADDR_W  block-aligned byte address.
- mem_resp_valid  in  1  block data valid (1-cycle pulse, one per accepted request).
- mem_resp_block  in  BLOCK_SIZE  block data; word k = bits [BLOCK_SIZE-1-k*WORD_SIZE -: WORD_SIZE].
- inst_valid  out  1  instruction available.
- inst_ready  in  1  decode accepts.
- inst  out  WORD_SIZE  instruction.
- inst_pc  out  ADDR_W  byte PC of inst.
- inst_count  out  32  instructions accepted since reset (wraps).

Behaviour:
- Definitions:
  - OFF_W = log2(BLOCK_WORDS).
  - Word offset = pc[OFF_W+1:2].
  - Block base = pc with bits [OFF_W+1:0] cleared.
  - PC increments by 4 per word.
- States: S_IDLE, S_REQ, S_WAIT, S_DROP, S_STREAM.
- Reset (rst_n=0 at edge): state S_IDLE, pc=0, ptr=0, line=0, inst_count=0. Outputs mem_req_valid=0, inst_valid=0, mem_req_addr=0, inst=0, inst_pc=0. Reset overrides every other event, including mid-stream and mid-request.
- S_IDLE:
  - Outputs idle.
  - redirect_valid → pc=redirect_pc, go to S_REQ.
- S_REQ:
  - mem_req_valid = !redirect_valid (combinational).
  - mem_req_addr = block base of pc.
  - Handshake (valid&ready) → S_WAIT.
  - redirect_valid → pc=redirect_pc, stay in S_REQ; no request issued that cycle.
- S_WAIT:
  - mem_resp_valid → line=mem_resp_block, ptr=word offset of pc, go to S_STREAM. First inst_valid appears the cycle after the response (1-cycle latency).
  - redirect_valid without mem_resp_valid → pc=redirect_pc, go to S_DROP.
  - redirect_valid with mem_resp_valid in the same cycle → discard the response, pc=redirect_pc, go to S_REQ.
- S_DROP:
  - Wait for the outstanding response and discard it, then go to S_REQ.
  - redirect_valid here → pc updated; stay in S_DROP, or go to S_REQ if the response arrives in the same cycle.
  - At most one request is ever outstanding.
- S_STREAM:
  - inst_valid=1, inst=line word[ptr], inst_pc=pc.
  - On inst_valid&inst_ready: pc+=4, inst_count+=1, ptr+=1.
  - If the accepted word had ptr==BLOCK_WORDS-1 → go to S_REQ. The new pc is the next block base, and the wrap of ptr to 0 is harmless.
  - inst, inst_pc and inst_valid hold stable while inst_ready=0.
  - redirect_valid: inst_valid is still 1 that cycle but no transfer is counted (redirect wins over handshake). pc=redirect_pc, go to S_REQ; the line register is not reused even when the new PC falls in the same block.
- PC arithmetic is modulo 2^ADDR_W; wrap from the top block to block 0 is legal.
- inst_count wraps modulo 2^32.
- Throughput: 1 instruction/cycle within a block. Block-crossing bubble ≥ 2 cycles (REQ, WAIT) plus instcache latency.

Decomposition:
- Shared package/define file (alongside define.v):
  - `WORD_SIZE`, `BLOCK_WORDS`, `BLOCK_SIZE`, `ADDR_W` defaults.
  - State encoding constants S_IDLE..S_STREAM (3 bits).
  - Helper macros for word-offset and block-base extraction.
- One sub-module is natural: block_word_sel, a combinational mux selecting word[ptr] from the BLOCK_SIZE line in MSB-first order. All sequencing stays in fetch_stream.

Test Plan:
- Sequential block: redirect to 0x0; respond with word k = k; inst_ready=1 → 32 insts with values 0..31 and PCs 0x00..0x7C on consecutive cycles; then mem_req_addr=0x80; inst_count=32.
- Mid-block entry: redirect to 0x74 → mem_req_addr=0x00; insts 29, 30, 31 at PCs 0x74, 0x78, 0x7C; next request 0x80.
- Backpressure: hold inst_ready=0 for 5 cycles at word 3 → inst/inst_pc stable, inst_count unchanged; release → resumes with word 3 then 4.
- Redirect in S_WAIT: redirect to 0x200 before the 0x80 response → stale block arriving later is discarded, a single request to 0x200 follows, and the first inst_pc is 0x200.
- Simultaneous events:
  - redirect together with mem_resp_valid → response dropped, immediate request to the new base.
  - redirect together with inst_ready → no count increment.
  - redirect in the same cycle as a would-be request handshake → mem_req_valid=0 that cycle.
- Reset mid-stream: rst_n=0 for 1 cycle during word 10 → next cycle all outputs 0, state S_IDLE, inst_count=0, and no request until the next redirect.
